// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz raster timing constants and coordinate type, shared by
// vga_control and the downstream bit generator.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Half-open interval test [lo, hi) on unsigned coordinates.
  function automatic logic in_span(coord_t x, coord_t lo, coord_t hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_control_if.sv
// Raster timing bundle from vga_control to the bit generator / connector.
// frameStart exists only when VGA_FRAME_PULSE_EN is defined.
interface vga_control_if;
  import vga_timing_pkg::*;

  logic   pixTick;
  logic   hSync;
  logic   vSync;
  logic   bright;
  coord_t hCount;
  coord_t vCount;
`ifdef VGA_FRAME_PULSE_EN
  logic   frameStart;

  modport master (output pixTick, output hSync, output vSync, output bright,
                  output hCount, output vCount, output frameStart);
  modport slave  (input pixTick, input hSync, input vSync, input bright,
                  input hCount, input vCount, input frameStart);
`else
  modport master (output pixTick, output hSync, output vSync, output bright,
                  output hCount, output vCount);
  modport slave  (input pixTick, input hSync, input vSync, input bright,
                  input hCount, input vCount);
`endif
endinterface

// File: rtl/pix_tick_gen.sv
// Pixel-rate enable: one-clk pulse every CLK_DIV board clocks, decoded from a
// wrapping phase counter. With CLK_DIV = 1 the pulse is constantly high.
module pix_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic pixTick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_tick_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == CNT_LAST) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CNT_W'(1);
    end
  end

  assign pixTick = (r_tick_cnt == CNT_LAST);

endmodule

// File: rtl/vga_control.sv
// VGA raster timing generator: pixel enable, registered hCount/vCount and
// glitch-free registered bright/hSync/vSync. Optional frameStart via VGA_FRAME_PULSE_EN.
module vga_control #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic          clk,
  input  logic          reset,
  vga_control_if.master vga
);

  typedef vga_timing_pkg::coord_t coord_t;

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST  = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST  = coord_t'(V_TOT - 1);
  localparam coord_t H_VIS   = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS   = coord_t'(V_VISIBLE);
  localparam coord_t HS_LO   = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_HI   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_LO   = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_HI   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  logic   w_pix_tick;
  logic   w_frame_wrap;
  coord_t w_h_nxt;
  coord_t w_v_nxt;
  coord_t r_h;
  coord_t r_v;
  logic   r_bright;
  logic   r_hsync;
  logic   r_vsync;

  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_pix_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .pixTick (w_pix_tick)
  );

  always_comb begin
    w_h_nxt      = r_h;
    w_v_nxt      = r_v;
    w_frame_wrap = 1'b0;
    if (w_pix_tick) begin
      if (r_h == H_LAST) begin
        w_h_nxt = '0;
        if (r_v == V_LAST) begin
          w_v_nxt      = '0;
          w_frame_wrap = 1'b1;
        end else begin
          w_v_nxt = r_v + coord_t'(1);
        end
      end else begin
        w_h_nxt = r_h + coord_t'(1);
      end
    end
  end

  // Flags decode the next-state coordinates so they land on the same edge as the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h      <= H_LAST;
      r_v      <= V_LAST;
      r_bright <= 1'b0;
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
    end else begin
      r_h      <= w_h_nxt;
      r_v      <= w_v_nxt;
      r_bright <= (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
      r_hsync  <= !vga_timing_pkg::in_span(w_h_nxt, HS_LO, HS_HI);
      r_vsync  <= !vga_timing_pkg::in_span(w_v_nxt, VS_LO, VS_HI);
    end
  end

`ifdef VGA_FRAME_PULSE_EN
  logic r_frame_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_wrap;
    end
  end

  assign vga.frameStart = r_frame_start;
`else
  logic w_unused_wrap;
  assign w_unused_wrap = w_frame_wrap;
`endif

  assign vga.pixTick = w_pix_tick;
  assign vga.hCount  = r_h;
  assign vga.vCount  = r_v;
  assign vga.bright  = r_bright;
  assign vga.hSync   = r_hsync;
  assign vga.vSync   = r_vsync;

endmodule
